booth_r4_seq_mult: RTL and testbench



---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_pp_select.sv | 25 ++
 rtl/booth_r4_enc.sv | 17 +
 rtl/booth_r4_seq_mult.sv | 98 +++++++++
 tb/tb_booth_r4_seq_mult.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier slice: FSM states, encoder bundle, digit count.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_enc_t;

    // Unsigned operands need one extra digit to absorb the zero-extended top bits.
    function automatic int unsigned digit_count(input int unsigned width, input logic tc);
        return tc ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_pp_select.sv
// Partial-product select: weighted multiplicand -> 0 / A / 2A, ones-complemented when negative.
// Latency: combinational. Backpressure: none.
// Negation completes through cin, which the accumulator adds as its carry-in.
module booth_pp_select
    import booth_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic [PW-1:0] a_w,
    input  booth_enc_t    enc,
    output logic [PW-1:0] pp,
    output logic          cin
);

    logic [PW-1:0] mag;

    always_comb begin
        mag = '0;
        if (!enc.zero)
            mag = enc.two ? (a_w << 1) : a_w;
        pp  = enc.neg ? ~mag : mag;
        cin = enc.neg;
    end

endmodule

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder cell: 3-bit window {b[2k+1], b[2k], b[2k-1]} to neg/two/zero.
// Latency: combinational. Backpressure: none.
// Both all-zeros and all-ones windows select zero; neg is never set together with zero.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]  win,
    output booth_enc_t  enc
);

    always_comb begin
        enc.zero = (win == 3'b000) || (win == 3'b111);
        enc.two  = (win == 3'b011) || (win == 3'b100);
        enc.neg  = win[2] && !enc.zero;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, unsigned or two's-complement per op.
// Latency: WIDTH/2 cycles (tc) or WIDTH/2+1 (unsigned) from accept to out_valid.
// Backpressure: holds product in DONE until out_ready; in_ready only in IDLE.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_tc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = WIDTH + 3;
    localparam int KW = $clog2(WIDTH / 2 + 2);

    state_t        state;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [BW-1:0] mplr;
    logic [KW-1:0] k;
    logic [KW-1:0] last_k;

    booth_enc_t    enc;
    logic [PW-1:0] pp;
    logic          cin;
    logic [PW-1:0] acc_nxt;

    // Window is always the low 3 bits; the multiplier register shifts right 2 per digit.
    booth_r4_enc u_enc (
        .win (mplr[2:0]),
        .enc (enc)
    );

    booth_pp_select #(.PW(PW)) u_pp (
        .a_w (mcand),
        .enc (enc),
        .pp  (pp),
        .cin (cin)
    );

    assign acc_nxt   = acc + pp + {{(PW-1){1'b0}}, cin};

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            k      <= '0;
            last_k <= '0;
            out_p  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand  <= in_tc ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
                        // b[-1]=0 below the LSB; two extension bits feed the extra unsigned digit.
                        mplr   <= {{2{in_tc & in_b[WIDTH-1]}}, in_b, 1'b0};
                        last_k <= KW'(digit_count(WIDTH, in_tc) - 1);
                        k      <= '0;
                        acc    <= '0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 2;
                    mplr  <= mplr >> 2;
                    k     <= k + 1'b1;
                    if (k == last_k) begin
                        out_p <= acc_nxt;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult at WIDTH=8: directed vectors plus an arithmetic reference model.
module tb_booth_r4_seq_mult;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_tc;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [2*W-1:0] p;
        int             n;
        int             acc;
    } exp_t;

    exp_t exp_q[$];
    bit   seen = 1'b0;

    booth_r4_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tc     (in_tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic tc);
        int x;
        int y;
        if (tc) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return 16'(x * y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle out_valid is high the product must equal the model's value for
    // the oldest accepted operation, and its first valid cycle must fall N cycles after accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("model_p", 32'(out_p), 32'(exp_q[0].p));
                    if (!seen)
                        check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].n));
                    seen = 1'b1;
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{p: model(in_a, in_b, in_tc), n: (in_tc ? W/2 : W/2 + 1), acc: cyc + 1});
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic tc);
        in_a     = a;
        in_b     = b;
        in_tc    = tc;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid)
                return;
        end
        check("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic tc,
                      input logic [2*W-1:0] exp_p, input string name);
        @(posedge clk);
        #1;
        drive(a, b, tc);
        wait_accept();
        wait_valid();
        check(name, 32'(out_p), 32'(exp_p));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_p"},     32'(out_p),     32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tc     = 1'b0;
        out_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
        op(8'h80, 8'h80, 1'b1, 16'h4000, "tc_m128xm128");
        op(8'hFF, 8'h01, 1'b1, 16'hFFFF, "tc_m1x1");
        op(8'h7F, 8'h80, 1'b1, 16'hC080, "tc_127xm128");
        op(8'h00, 8'hAB, 1'b0, 16'h0000, "u_0xAB");
        op(8'hAB, 8'h00, 1'b0, 16'h0000, "u_ABx0");
        op(8'h00, 8'hAB, 1'b1, 16'h0000, "tc_0xAB");
        op(8'hAB, 8'h00, 1'b1, 16'h0000, "tc_ABx0");

        // Backpressure: product held in DONE while a second operation waits at the input.
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        drive(8'h12, 8'h34, 1'b0);
        wait_accept();
        wait_valid();
        drive(8'h05, 8'h06, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_p",     32'(out_p),     32'h03A8);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("drain_in_ready",  32'(in_ready),  32'd1);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("pend_in_ready", 32'(in_ready), 32'd0);
        check("pend_busy",     32'(busy),     32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        check("pend_5x6", 32'(out_p), 32'h001E);
        @(posedge clk);
        #1;

        // Asynchronous reset while digit 2 is being accumulated.
        drive(8'h37, 8'h59, 1'b0);
        wait_accept();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(8'h03, 8'h05, 1'b0, 16'h000F, "u_3x5_after_reset");

        // Back-to-back random stream checked by the scoreboard.
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) begin
            drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_accept();
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0)
                break;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
